// File: rtl/branch_predictor_bht_pkg.sv
// branch_predictor_bht_pkg: shared sizing and saturating-counter constants for the BHT
package branch_predictor_bht_pkg;
  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction
  function automatic int ctr_max(input int w);
    return (1 << w) - 1;
  endfunction
  function automatic int ctr_init(input int w);
    return 1 << (w - 1);
  endfunction
endpackage

// File: rtl/branch_predictor_bht_sat_counter.sv
// sat_counter: next-state of a CTR_W-bit saturating up/down counter
//   ctr_i : current count
//   up_i  : 1 = increment, 0 = decrement
//   ctr_o : next count, clamped to [0, 2^CTR_W-1]
module sat_counter
  import branch_predictor_bht_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             up_i,
  output logic [CTR_W-1:0] ctr_o
);
  localparam logic [CTR_W-1:0] MAX = CTR_W'(ctr_max(CTR_W));
  always_comb
    ctr_o = up_i ? (ctr_i == MAX ? ctr_i : ctr_i + 1'b1)
                 : (ctr_i == '0  ? ctr_i : ctr_i - 1'b1);
endmodule

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: direct-mapped tagged branch history table with target store
//   clk, reset (async active-low)
//   lookup_pc -> predict_hit / predict_taken / predict_target (combinational read)
//   update_valid/pc/taken/target/mispredict : resolved-branch training port
//   flush_table : invalidate all entries at next edge
//   branch_count / mispredict_count : wrapping 32-bit statistics
module branch_predictor_bht
  import branch_predictor_bht_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int TAG_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              predict_taken,
  output logic [ADDR_W-1:0] predict_target,
  output logic              predict_hit,
  input  logic              update_valid,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic              update_taken,
  input  logic [ADDR_W-1:0] update_target,
  input  logic              update_mispredict,
  input  logic              flush_table,
  output logic [31:0]       branch_count,
  output logic [31:0]       mispredict_count
);
  localparam int IDX_W = idx_w(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q [ENTRIES];
  logic [31:0]        br_q, br_d, mis_q, mis_d;
  logic [IDX_W-1:0]   l_idx, u_idx;
  logic [TAG_W-1:0]   l_tag, u_tag;
  logic [CTR_W-1:0]   ctr_cur, ctr_nxt;
  logic               u_hit, alloc, tbl_we;
  logic               unused_pc;
  assign unused_pc = ^{lookup_pc, update_pc};
  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx = update_pc[IDX_W+1:2];
  assign u_tag = update_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign predict_hit    = valid_q[l_idx] && tag_q[l_idx] == l_tag;
  assign predict_taken  = predict_hit && ctr_q[l_idx][CTR_W-1];
  assign predict_target = predict_taken ? tgt_q[l_idx] : lookup_pc + ADDR_W'(4);
  assign ctr_cur = ctr_q[u_idx];
  sat_counter #(.CTR_W(CTR_W)) u_sat (
    .ctr_i(ctr_cur),
    .up_i (update_taken),
    .ctr_o(ctr_nxt)
  );
  assign u_hit  = valid_q[u_idx] && tag_q[u_idx] == u_tag;
  assign alloc  = update_valid && !flush_table && !u_hit && update_taken;
  // reset gates the data arrays so an update coincident with reset is dropped
  assign tbl_we = update_valid && !flush_table && reset && (u_hit || update_taken);
  always_comb begin
    valid_d = valid_q;
    if (flush_table) valid_d = '0;
    else if (alloc) valid_d[u_idx] = 1'b1;
    br_d  = update_valid ? br_q + 32'd1 : br_q;
    mis_d = update_valid && update_mispredict ? mis_q + 32'd1 : mis_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      valid_q <= '0;
      br_q    <= '0;
      mis_q   <= '0;
    end else begin
      valid_q <= valid_d;
      br_q    <= br_d;
      mis_q   <= mis_d;
    end
  // tag/target/counter storage is unreset; valid masks stale contents
  always_ff @(posedge clk)
    if (tbl_we) begin
      ctr_q[u_idx] <= u_hit ? ctr_nxt : CTR_INIT;
      if (update_taken) begin
        tag_q[u_idx] <= u_tag;
        tgt_q[u_idx] <= update_target;
      end
    end
  assign branch_count     = br_q;
  assign mispredict_count = mis_q;
endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht: directed self-checking bench for branch_predictor_bht
module tb_branch_predictor_bht;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] lookup_pc;
  logic        predict_taken;
  logic [63:0] predict_target;
  logic        predict_hit;
  logic        update_valid;
  logic [63:0] update_pc;
  logic        update_taken;
  logic [63:0] update_target;
  logic        update_mispredict;
  logic        flush_table;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
  int n_chk = 0;
  int n_fail = 0;
  int eb = 0;
  int em = 0;

  branch_predictor_bht dut (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
    .predict_taken(predict_taken), .predict_target(predict_target), .predict_hit(predict_hit),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .flush_table(flush_table), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [63:0] pc, input logic h, input logic t, input logic [63:0] tg);
    lookup_pc = pc;
    #1;
    chk({tag, "_hit"}, {63'd0, predict_hit}, {63'd0, h});
    chk({tag, "_taken"}, {63'd0, predict_taken}, {63'd0, t});
    chk({tag, "_target"}, predict_target, tg);
  endtask

  task automatic counts(input string tag);
    chk({tag, "_brcnt"}, {32'd0, branch_count}, 64'(eb));
    chk({tag, "_miscnt"}, {32'd0, mispredict_count}, 64'(em));
  endtask

  task automatic upd(input logic [63:0] pc, input logic tk, input logic [63:0] tg, input logic mis, input logic fl);
    update_valid = 1'b1;
    update_pc = pc;
    update_taken = tk;
    update_target = tg;
    update_mispredict = mis;
    flush_table = fl;
    @(posedge clk);
    #1;
    if (reset) begin
      eb++;
      if (mis) em++;
    end
    update_valid = 1'b0;
    update_mispredict = 1'b0;
    flush_table = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    lookup_pc = 64'h100;
    update_valid = 1'b0;
    update_pc = '0;
    update_taken = 1'b0;
    update_target = '0;
    update_mispredict = 1'b0;
    flush_table = 1'b0;
    look("reset", 64'h100, 1'b0, 1'b0, 64'h104);
    counts("reset");
    @(posedge clk);
    #1 reset = 1'b1;
    look("empty", 64'h100, 1'b0, 1'b0, 64'h104);
    upd(64'h100, 1'b1, 64'h40, 1'b1, 1'b0);
    look("alloc", 64'h100, 1'b1, 1'b1, 64'h40);
    counts("alloc");
    upd(64'h100, 1'b0, 64'h0, 1'b0, 1'b0);
    look("nt1", 64'h100, 1'b1, 1'b0, 64'h104);
    upd(64'h100, 1'b0, 64'h0, 1'b0, 1'b0);
    look("nt2", 64'h100, 1'b1, 1'b0, 64'h104);
    upd(64'h100, 1'b0, 64'h0, 1'b0, 1'b0);
    look("nt3", 64'h100, 1'b1, 1'b0, 64'h104);
    upd(64'h100, 1'b1, 64'h80, 1'b0, 1'b0);
    look("t_from0", 64'h100, 1'b1, 1'b0, 64'h104);
    upd(64'h100, 1'b1, 64'h80, 1'b0, 1'b0);
    look("t_to2", 64'h100, 1'b1, 1'b1, 64'h80);
    upd(64'h100, 1'b1, 64'h88, 1'b0, 1'b0);
    upd(64'h100, 1'b1, 64'h88, 1'b0, 1'b0);
    upd(64'h100, 1'b0, 64'h0, 1'b0, 1'b0);
    look("sat_hi", 64'h100, 1'b1, 1'b1, 64'h88);
    upd(64'h140, 1'b1, 64'h300, 1'b0, 1'b0);
    look("alias_old", 64'h100, 1'b0, 1'b0, 64'h104);
    look("alias_new", 64'h140, 1'b1, 1'b1, 64'h300);
    upd(64'h204, 1'b0, 64'h500, 1'b0, 1'b0);
    look("miss_nt", 64'h204, 1'b0, 1'b0, 64'h208);
    upd(64'h200, 1'b1, 64'h600, 1'b1, 1'b1);
    look("flush_new", 64'h200, 1'b0, 1'b0, 64'h204);
    look("flush_old", 64'h140, 1'b0, 1'b0, 64'h144);
    counts("flush");
    #3 reset = 1'b0;
    eb = 0;
    em = 0;
    #1;
    counts("reset2");
    @(posedge clk);
    #1 reset = 1'b1;
    upd(64'h100, 1'b1, 64'h40, 1'b1, 1'b0);
    upd(64'h100, 1'b0, 64'h0, 1'b0, 1'b0);
    upd(64'h104, 1'b1, 64'h44, 1'b1, 1'b0);
    upd(64'h100, 1'b1, 64'h40, 1'b0, 1'b0);
    upd(64'h108, 1'b0, 64'h0, 1'b0, 1'b0);
    counts("five");
    chk("five_br_const", {32'd0, branch_count}, 64'd5);
    chk("five_mis_const", {32'd0, mispredict_count}, 64'd2);
    look("pre_async", 64'h104, 1'b1, 1'b1, 64'h44);
    #3 reset = 1'b0;
    eb = 0;
    em = 0;
    #1;
    counts("async");
    look("async", 64'h104, 1'b0, 1'b0, 64'h108);
    upd(64'h10C, 1'b1, 64'h70, 1'b1, 1'b0);
    #1 reset = 1'b1;
    look("upd_in_reset", 64'h10C, 1'b0, 1'b0, 64'h110);
    counts("upd_in_reset");
    look("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predictor_bht.md
BRANCH_PREDICTOR_BHT -- requirements
Module: branch_predictor_bht

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, PC and target width.
REQ-002 SHALL have parameter ENTRIES, default 16, table depth; power of two, at least 2.
REQ-003 SHALL have parameter CTR_W, default 2, saturating counter width, 1 to 4.
REQ-004 SHALL have parameter TAG_W, default 8, stored PC tag bits.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low; table and statistics cleared while low.
REQ-007 SHALL have port lookup_pc, input, ADDR_W: PC of the instruction in fetch.
REQ-008 SHALL have port predict_taken, output, 1: predicted taken.
REQ-009 SHALL have port predict_target, output, ADDR_W: next fetch PC.
REQ-010 SHALL have port predict_hit, output, 1: valid entry with matching tag.
REQ-011 SHALL have port update_valid, input, 1: resolved branch present this cycle.
REQ-012 SHALL have port update_pc, input, ADDR_W: PC of the resolved branch.
REQ-013 SHALL have port update_taken, input, 1: resolved outcome.
REQ-014 SHALL have port update_target, input, ADDR_W: resolved taken target.
REQ-015 SHALL have port update_mispredict, input, 1: pipeline flushed for this branch.
REQ-016 SHALL have port flush_table, input, 1: invalidate all entries.
REQ-017 SHALL have port branch_count, output, 32: resolved branches counted.
REQ-018 SHALL have port mispredict_count, output, 32: mispredictions counted.

Function
REQ-019 SHALL form the index as pc[IDX_W+1:2] and the tag as pc[IDX_W+TAG_W+1:IDX_W+2], where IDX_W=log2(ENTRIES).
REQ-020 SHALL set predict_hit combinationally from lookup_pc, with zero cycles of latency: valid[idx] AND tag equal.
REQ-021 SHALL drive predict_taken = predict_hit AND counter MSB.
REQ-022 SHALL drive predict_target = stored target when predict_taken, else lookup_pc+4 (ADDR_W wrap).
REQ-023 SHALL, on update_valid with hit on update_pc, increment the counter when taken and decrement it when not taken, saturating at 2^CTR_W-1 and 0; target rewritten when taken.
REQ-024 SHALL, on update_valid with miss and taken, allocate the entry (overwrite): valid=1, tag, target, counter = 2^(CTR_W-1) (weakly taken).
REQ-025 SHALL make no table change on update_valid with miss and not taken.
REQ-026 SHALL, on update_valid, increment branch_count by 1 and increment mispredict_count by 1 when update_mispredict is also set; both wrap at 2^32.
REQ-027 SHALL give a lookup and an update to the same index in one cycle the pre-update entry (no bypass); the new state is visible the next cycle.
REQ-028 SHALL, on flush_table, clear all valid bits at the next edge; flush beats a coincident update (no allocate or counter change), but the counters still count.
REQ-029 SHALL update the table state only on clk rising edge; outputs carry no glitch-sensitive logic beyond table read.

Reset
REQ-030 SHALL, with reset low, immediately force all valid bits to 0, branch_count=0, mispredict_count=0; predict_hit=0, predict_taken=0, predict_target=lookup_pc+4.
REQ-031 SHALL leave tag, target and counter arrays unreset; they are masked by valid.
REQ-032 SHALL discard an update coincident with reset assertion; operation resumes on the first edge after release.

Structure
REQ-033 SHALL place counter-init and saturation helper constants plus the IDX_W derivation in the shared processor package.
REQ-034 SHALL use one sub-module, sat_counter (CTR_W-bit saturating up/down), instantiated per entry or as a shared next-state function.

Verification
REQ-035 SHALL verify: reset low, lookup_pc=0x100 -> predict_hit=0, predict_taken=0, predict_target=0x104, both counts 0.
REQ-036 SHALL verify: update pc=0x100 taken target=0x40 -> next cycle lookup 0x100 gives hit=1, taken=1, target=0x40, branch_count=1.
REQ-037 SHALL verify: from weakly taken, two not-taken updates -> taken=0 after first (counter 01), counter 00 after second; a third not-taken update stays 00.
REQ-038 SHALL verify aliasing: pc 0x100 allocated, then taken update to 0x140 (same index, ENTRIES=16) -> lookup 0x100 hit=0, lookup 0x140 hit=1.
REQ-039 SHALL verify: flush_table together with a taken update to 0x200 -> next cycle no hits anywhere, branch_count incremented.
REQ-040 SHALL verify: 5 updates with update_mispredict on 2 of them -> branch_count=5, mispredict_count=2; asynchronous reset mid-sequence returns both to 0 immediately.
